round_sequencer: RTL

Parametrised control FSM that sequences an iterated datapath (cipher rounds, key-derivation iterations) on behalf of several requesting channels. It arbitrates channel requests round-robin, loads the datapath, and issues one step per iteration, waiting for the datapath's per-round completion. It reports completion, error or abort per job. It sits between the request front-end and the round datapath, replacing a fixed single-channel controller.

---
 rtl/round_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: round-robin job arbiter and step sequencer for an
// iterated datapath. One job runs at a time. Each job is a load pulse,
// then one step per iteration, and each step waits for the datapath's
// per-round completion. A job ends with a done pulse that carries the
// err and aborted flags.
module round_sequencer #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [N_CH-1:0]        req_i,
    input  logic [N_CH*CNT_W-1:0]  iter_cnt_i,
    input  logic                   abort_i,
    input  logic                   dp_valid_i,
    output logic [N_CH-1:0]        gnt_o,
    output logic                   busy_o,
    output logic [CH_W-1:0]        ch_id_o,
    output logic                   load_o,
    output logic                   step_o,
    output logic                   last_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   aborted_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CH_W-1:0]    chId_q, chId_d;
    logic [CH_W-1:0]    lastGnt_q, lastGnt_d;
    logic               err_q, err_d;
    logic               aborted_q, aborted_d;

    logic [N_CH-1:0]    gnt_q, gnt_d;
    logic               busy_q, load_q, step_q, last_q, done_q;

    logic               found;
    logic [CH_W-1:0]    sel;
    logic [CH_W-1:0]    cand;
    logic [CNT_W-1:0]   selCnt;

    // Round-robin search: first requesting channel upward from the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int off = 1; off <= N_CH; off++) begin
            cand = CH_W'((int'(lastGnt_q) + off) % N_CH);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        selCnt = iter_cnt_i[int'(sel)*CNT_W +: CNT_W];
    end

    // Next-state logic. Abort overrides dp_valid, and rem never drops below zero.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        chId_d    = chId_q;
        lastGnt_d = lastGnt_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        gnt_d     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    chId_d     = sel;
                    lastGnt_d  = sel;
                    rem_d      = selCnt;
                    aborted_d  = 1'b0;
                    gnt_d[sel] = 1'b1;
                    if (selCnt == '0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (dp_valid_i) begin
                    state_d = (rem_q == '0) ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers and output registers. Outputs are decoded from the state being entered.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            chId_q    <= '0;
            lastGnt_q <= CH_W'(N_CH - 1);
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
            step_q    <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            chId_q    <= chId_d;
            lastGnt_q <= lastGnt_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            gnt_q     <= gnt_d;
            busy_q    <= (state_d != IDLE);
            load_q    <= (state_d == LOAD);
            step_q    <= (state_d == ISSUE);
            last_q    <= (state_d == ISSUE) && (rem_d == CNT_W'(1));
            done_q    <= (state_d == DONE);
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign ch_id_o   = chId_q;
    assign load_o    = load_q;
    assign step_o    = step_q;
    assign last_o    = last_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign aborted_o = aborted_q;

endmodule
